// File: rtl/interrupt_controller.sv
// Two-class (IRQ/FIQ) interrupt controller: synchronized sources, level/edge pending logic,
// lowest-index priority and one request/service FSM per class.
module interrupt_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  IntSrc,
    input  logic        IRQAssert,
    input  logic        FIQAssert,
    input  logic        CfgWE,
    input  logic [2:0]  CfgAddr,
    input  logic [31:0] CfgWD,
    output logic [31:0] CfgRD,
    output logic        IRQ,
    output logic        FIQ
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] ID_NONE = 4'hF;

    logic [7:0] s;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            always_comb sync_d = {sync_q[SYNC_STAGES-2:0], IntSrc[gi]};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) sync_q <= '0;
                else       sync_q <= sync_d;
            end

            assign s[gi] = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [7:0] enable_q,   enable_d;
    logic [7:0] fiqsel_q,   fiqsel_d;
    logic [7:0] edge_sel_q, edge_sel_d;
    logic [7:0] pend_edge_q, pend_edge_d;
    logic [7:0] hist_q,     hist_d;
    state_t     irq_state_q, irq_state_d;
    state_t     fiq_state_q, fiq_state_d;
    logic [3:0] irq_id_q,   irq_id_d;
    logic [3:0] fiq_id_q,   fiq_id_d;
    logic       irq_q,      irq_d;
    logic       fiq_q,      fiq_d;

    logic [7:0] w1c_mask;
    logic       irq_eoi, fiq_eoi;
    logic [7:0] pend_set, pending, eligible, irq_set, fiq_set;
    logic [3:0] irq_pick, fiq_pick;
    logic       irq_take, fiq_take;
    logic [7:0] irq_clr, fiq_clr;
    logic       unused_cfg_bits;

    assign unused_cfg_bits = ^CfgWD[31:8];

    function automatic logic [3:0] lowest_id(input logic [7:0] v);
        lowest_id = ID_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_id = 4'(i);
        end
    endfunction

    always_comb begin
        enable_d   = enable_q;
        fiqsel_d   = fiqsel_q;
        edge_sel_d = edge_sel_q;
        if (CfgWE) begin
            case (CfgAddr)
                3'd0:    enable_d   = CfgWD[7:0];
                3'd1:    fiqsel_d   = CfgWD[7:0];
                3'd2:    edge_sel_d = CfgWD[7:0];
                default: ;
            endcase
        end
    end

    assign w1c_mask = (CfgWE && CfgAddr == 3'd3) ? CfgWD[7:0] : 8'd0;
    assign irq_eoi  = CfgWE && (CfgAddr == 3'd6) && CfgWD[0];
    assign fiq_eoi  = CfgWE && (CfgAddr == 3'd6) && CfgWD[1];

    // A freshly detected edge counts as pending in the same cycle, so edge and level
    // sources see the same synchronizer-to-request latency.
    assign pend_set = s & ~hist_q & edge_sel_q;
    assign pending  = (edge_sel_q & (pend_edge_q | pend_set)) | (~edge_sel_q & s);
    assign eligible = pending & enable_q;
    assign fiq_set  = eligible & fiqsel_q;
    assign irq_set  = eligible & ~fiqsel_q;
    assign irq_pick = lowest_id(irq_set);
    assign fiq_pick = lowest_id(fiq_set);

    assign irq_take = (irq_state_q == ST_REQ) && IRQAssert;
    assign fiq_take = (fiq_state_q == ST_REQ) && FIQAssert;
    assign irq_clr  = (irq_take && irq_pick != ID_NONE) ? (8'd1 << irq_pick[2:0]) : 8'd0;
    assign fiq_clr  = (fiq_take && fiq_pick != ID_NONE) ? (8'd1 << fiq_pick[2:0]) : 8'd0;

    // Set wins over W1C/ack clear; latched bits are dropped once a source leaves edge mode.
    assign pend_edge_d = ((pend_edge_q & ~(w1c_mask | irq_clr | fiq_clr)) | pend_set) & edge_sel_d;
    assign hist_d      = s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q    <= '0;
            fiqsel_q    <= '0;
            edge_sel_q  <= '0;
            pend_edge_q <= '0;
            hist_q      <= '0;
            irq_state_q <= ST_IDLE;
            fiq_state_q <= ST_IDLE;
            irq_id_q    <= ID_NONE;
            fiq_id_q    <= ID_NONE;
            irq_q       <= 1'b0;
            fiq_q       <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            fiqsel_q    <= fiqsel_d;
            edge_sel_q  <= edge_sel_d;
            pend_edge_q <= pend_edge_d;
            hist_q      <= hist_d;
            irq_state_q <= irq_state_d;
            fiq_state_q <= fiq_state_d;
            irq_id_q    <= irq_id_d;
            fiq_id_q    <= fiq_id_d;
            irq_q       <= irq_d;
            fiq_q       <= fiq_d;
        end
    end

    always_comb begin
        irq_state_d = irq_state_q;
        case (irq_state_q)
            ST_IDLE:    if (|irq_set) irq_state_d = ST_REQ;
            ST_REQ: begin
                if (IRQAssert)      irq_state_d = ST_SERVICE;
                else if (~|irq_set) irq_state_d = ST_IDLE;
            end
            ST_SERVICE: if (irq_eoi) irq_state_d = ST_IDLE;
            default:    irq_state_d = ST_IDLE;
        endcase

        fiq_state_d = fiq_state_q;
        case (fiq_state_q)
            ST_IDLE:    if (|fiq_set) fiq_state_d = ST_REQ;
            ST_REQ: begin
                if (FIQAssert)      fiq_state_d = ST_SERVICE;
                else if (~|fiq_set) fiq_state_d = ST_IDLE;
            end
            ST_SERVICE: if (fiq_eoi) fiq_state_d = ST_IDLE;
            default:    fiq_state_d = ST_IDLE;
        endcase
    end

    // Requests are flopped copies of "next state is REQ", so IRQ/FIQ come straight off a flop.
    always_comb begin
        irq_d    = (irq_state_d == ST_REQ);
        fiq_d    = (fiq_state_d == ST_REQ);
        irq_id_d = irq_id_q;
        fiq_id_d = fiq_id_q;
        if (irq_take)                                    irq_id_d = irq_pick;
        else if (irq_state_q == ST_SERVICE && irq_eoi)   irq_id_d = ID_NONE;
        if (fiq_take)                                    fiq_id_d = fiq_pick;
        else if (fiq_state_q == ST_SERVICE && fiq_eoi)   fiq_id_d = ID_NONE;
    end

    always_comb begin
        CfgRD = '0;
        case (CfgAddr)
            3'd0:    CfgRD[7:0] = enable_q;
            3'd1:    CfgRD[7:0] = fiqsel_q;
            3'd2:    CfgRD[7:0] = edge_sel_q;
            3'd3:    CfgRD[7:0] = pending;
            3'd4:    CfgRD[3:0] = irq_id_q;
            3'd5:    CfgRD[3:0] = fiq_id_q;
            default: CfgRD      = '0;
        endcase
    end

    assign IRQ = irq_q;
    assign FIQ = fiq_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus a randomized phase, all checked against a cycle model of the
// controller's documented behaviour.
module tb_interrupt_controller;
    localparam int SYNC = 2;

    logic        clk, reset;
    logic [7:0]  IntSrc;
    logic        IRQAssert, FIQAssert, CfgWE;
    logic [2:0]  CfgAddr;
    logic [31:0] CfgWD, CfgRD;
    logic        IRQ, FIQ;

    int n_assert = 0;
    int n_fail   = 0;

    interrupt_controller #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .IntSrc(IntSrc),
        .IRQAssert(IRQAssert), .FIQAssert(FIQAssert),
        .CfgWE(CfgWE), .CfgAddr(CfgAddr), .CfgWD(CfgWD), .CfgRD(CfgRD),
        .IRQ(IRQ), .FIQ(FIQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: per-class state 0=idle 1=requesting 2=in service.
    bit [7:0] m_en, m_fsel, m_edge, m_latch, m_prevs;
    bit [7:0] m_pipe [SYNC];
    int       m_state [2];
    int       m_id [2];

    function automatic bit [7:0] m_pend();
        bit [7:0] sv = m_pipe[SYNC-1];
        bit [7:0] p = '0;
        for (int n = 0; n < 8; n++) begin
            if (m_edge[n]) p[n] = m_latch[n] | (sv[n] & !m_prevs[n]);
            else           p[n] = sv[n];
        end
        return p;
    endfunction

    function automatic bit [31:0] m_read(input bit [2:0] a);
        case (a)
            3'd0: return {24'd0, m_en};
            3'd1: return {24'd0, m_fsel};
            3'd2: return {24'd0, m_edge};
            3'd3: return {24'd0, m_pend()};
            3'd4: return 32'(m_id[0]);
            3'd5: return 32'(m_id[1]);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_fsel = 0; m_edge = 0; m_latch = 0; m_prevs = 0;
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
        m_state[0] = 0; m_state[1] = 0;
        m_id[0] = 15;   m_id[1] = 15;
    endtask

    task automatic model_clock();
        bit [7:0] sv, pend, elig, cls, clr, rises, w1c, new_edge;
        bit       ack, eoi;
        int       first;
        if (reset) begin
            model_reset();
            return;
        end
        sv   = m_pipe[SYNC-1];
        pend = m_pend();
        elig = pend & m_en;
        clr  = 0;
        for (int c = 0; c < 2; c++) begin
            ack = (c == 0) ? IRQAssert : FIQAssert;
            eoi = CfgWE && CfgAddr == 3'd6 && CfgWD[c];
            cls = (c == 0) ? (elig & ~m_fsel) : (elig & m_fsel);
            first = 15;
            for (int n = 7; n >= 0; n--) if (cls[n]) first = n;
            if (m_state[c] == 0) begin
                if (cls != 0) m_state[c] = 1;
            end else if (m_state[c] == 1) begin
                if (ack) begin
                    m_state[c] = 2;
                    m_id[c] = first;
                    if (first != 15 && m_edge[first]) clr[first] = 1'b1;
                end else if (cls == 0) begin
                    m_state[c] = 0;
                end
            end else if (eoi) begin
                m_state[c] = 0;
                m_id[c] = 15;
            end
        end
        rises    = sv & ~m_prevs & m_edge;
        w1c      = (CfgWE && CfgAddr == 3'd3) ? CfgWD[7:0] : 8'd0;
        new_edge = (CfgWE && CfgAddr == 3'd2) ? CfgWD[7:0] : m_edge;
        m_latch  = ((m_latch & ~(clr | w1c)) | rises) & new_edge;
        if (CfgWE && CfgAddr == 3'd0) m_en   = CfgWD[7:0];
        if (CfgWE && CfgAddr == 3'd1) m_fsel = CfgWD[7:0];
        m_edge  = new_edge;
        m_prevs = sv;
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = IntSrc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        chk("irq_vs_model", {31'd0, IRQ}, {31'd0, m_state[0] == 1});
        chk("fiq_vs_model", {31'd0, FIQ}, {31'd0, m_state[1] == 1});
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        CfgAddr = a;
        #1;
        d = CfgRD;
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
        CfgWE = 1'b1; CfgAddr = a; CfgWD = d;
        step();
        CfgWE = 1'b0; CfgWD = '0;
    endtask

    task automatic ack_irq();
        IRQAssert = 1'b1;
        step();
        IRQAssert = 1'b0;
    endtask

    task automatic ack_fiq();
        FIQAssert = 1'b1;
        step();
        FIQAssert = 1'b0;
    endtask

    task automatic do_reset();
        IntSrc = '0; IRQAssert = 0; FIQAssert = 0; CfgWE = 0; CfgAddr = '0; CfgWD = '0;
        reset = 1'b1;
        #1;
        chk("reset_irq_low", {31'd0, IRQ}, 32'd0);
        chk("reset_fiq_low", {31'd0, FIQ}, 32'd0);
        model_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        reset = 1'b1;
        IntSrc = '0; IRQAssert = 0; FIQAssert = 0; CfgWE = 0; CfgAddr = '0; CfgWD = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        rd(3'd4, d); chk("reset_irqid", d, 32'hF);
        rd(3'd5, d); chk("reset_fiqid", d, 32'hF);
        rd(3'd0, d); chk("reset_enable", d, 32'h0);

        // Level source 0: latency, ack, EOI re-request
        cfg_wr(3'd0, 32'h01);
        IntSrc = 8'h01;
        step(); chk("a_lat1", {31'd0, IRQ}, 32'd0);
        step(); chk("a_lat2", {31'd0, IRQ}, 32'd0);
        step(); chk("a_lat3", {31'd0, IRQ}, 32'd1);
        ack_irq(); chk("a_ack_irq", {31'd0, IRQ}, 32'd0);
        rd(3'd4, d); chk("a_irqid", d, 32'h0);
        cfg_wr(3'd6, 32'h1); chk("a_eoi_edge1", {31'd0, IRQ}, 32'd0);
        rd(3'd4, d); chk("a_irqid_eoi", d, 32'hF);
        step(); chk("a_eoi_edge2", {31'd0, IRQ}, 32'd1);

        // Edge sources 4 (IRQ) and 5 (FIQ) together
        do_reset();
        cfg_wr(3'd0, 32'h30); cfg_wr(3'd1, 32'h20); cfg_wr(3'd2, 32'h30);
        IntSrc = 8'h30; step(); IntSrc = 8'h00; step(); step();
        chk("b_irq", {31'd0, IRQ}, 32'd1);
        chk("b_fiq", {31'd0, FIQ}, 32'd1);
        ack_fiq();
        rd(3'd5, d); chk("b_fiqid", d, 32'h5);
        rd(3'd3, d); chk("b_pend1", d, 32'h10);
        ack_irq();
        rd(3'd4, d); chk("b_irqid", d, 32'h4);
        rd(3'd3, d); chk("b_pend0", d, 32'h00);

        // Priority between edge sources 2 and 3
        do_reset();
        cfg_wr(3'd0, 32'h0C); cfg_wr(3'd2, 32'h0C);
        IntSrc = 8'h0C; step(); IntSrc = 8'h00; step(); step();
        chk("c_irq", {31'd0, IRQ}, 32'd1);
        ack_irq();
        rd(3'd4, d); chk("c_irqid2", d, 32'h2);
        rd(3'd3, d); chk("c_pend", d, 32'h08);
        cfg_wr(3'd6, 32'h1); step();
        chk("c_rereq", {31'd0, IRQ}, 32'd1);
        ack_irq();
        rd(3'd4, d); chk("c_irqid3", d, 32'h3);

        // Level withdrawal, late ack, spurious ack
        do_reset();
        cfg_wr(3'd0, 32'h02);
        IntSrc = 8'h02; step(); step(); step();
        chk("d_irq", {31'd0, IRQ}, 32'd1);
        IntSrc = 8'h00; step(); step(); step();
        chk("d_withdrawn", {31'd0, IRQ}, 32'd0);
        ack_irq();
        rd(3'd4, d); chk("d_late_ack_id", d, 32'hF);
        IntSrc = 8'h02; step(); step(); step();
        chk("d_late_ack_ignored", {31'd0, IRQ}, 32'd1);
        IntSrc = 8'h00; step(); step();
        chk("d_still_req", {31'd0, IRQ}, 32'd1);
        ack_irq();
        rd(3'd4, d); chk("d_spurious_id", d, 32'hF);
        IntSrc = 8'h02; step(); step(); step();
        chk("d_service_holds", {31'd0, IRQ}, 32'd0);
        cfg_wr(3'd6, 32'h1); step();
        chk("d_after_eoi", {31'd0, IRQ}, 32'd1);

        // W1C racing a new edge on source 6
        do_reset();
        cfg_wr(3'd0, 32'h40); cfg_wr(3'd2, 32'h40);
        IntSrc = 8'h40; step(); IntSrc = 8'h00; step(); step();
        rd(3'd3, d); chk("e_pend_set", d, 32'h40);
        ack_irq();
        rd(3'd3, d); chk("e_pend_acked", d, 32'h00);
        IntSrc = 8'h40; step(); IntSrc = 8'h00; step();
        cfg_wr(3'd3, 32'h40);
        rd(3'd3, d); chk("e_set_beats_clear", d, 32'h40);
        cfg_wr(3'd3, 32'h40);
        rd(3'd3, d); chk("e_w1c", d, 32'h00);
        chk("e_irq_service", {31'd0, IRQ}, 32'd0);

        // Asynchronous reset while FIQ in service
        do_reset();
        cfg_wr(3'd1, 32'h80); cfg_wr(3'd0, 32'h80);
        IntSrc = 8'h80; step(); step(); step();
        chk("f_fiq", {31'd0, FIQ}, 32'd1);
        ack_fiq();
        rd(3'd5, d); chk("f_fiqid7", d, 32'h7);
        reset = 1'b1;
        #1;
        chk("f_async_fiq", {31'd0, FIQ}, 32'd0);
        rd(3'd5, d); chk("f_async_fiqid", d, 32'hF);
        rd(3'd0, d); chk("f_async_enable", d, 32'h0);
        model_reset();
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("f_no_req", {31'd0, FIQ}, 32'd0);
        cfg_wr(3'd1, 32'h80); cfg_wr(3'd0, 32'h80); step();
        chk("f_reconfig", {31'd0, FIQ}, 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 4) == 0) IntSrc = IntSrc ^ 8'(1 << $urandom_range(0, 7));
            IRQAssert = ($urandom_range(0, 5) == 0);
            FIQAssert = ($urandom_range(0, 5) == 0);
            CfgWE     = ($urandom_range(0, 5) == 0);
            CfgWD     = $urandom;
            rd(3'($urandom_range(0, 7)), d);
            chk("rand_cfgrd", d, m_read(CfgAddr));
            step();
        end
        IRQAssert = 0; FIQAssert = 0; CfgWE = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
